// File: rtl/csr_file.sv
// Machine/supervisor CSR file that sits in the MEM stage.
// It executes Zicsr read-modify-write ops, ecall/unimp traps and mret/sret.
// Trap and return events produce a registered one-cycle redirect/flush pulse.
// The instruction in the redirect slot is on the wrong path and is squashed.
// Optional feature macro: CSR_SMODE_EN adds the S-mode CSRs and sret.
// Without that macro, S-mode CSRs read as 0, writes to them are dropped, and sret does nothing.
module csr_file #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter logic [31:0] STVEC_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        csrfilein_valid,
    input  logic        csrfilein_stall,
    input  logic [31:0] csrfilein_inst,
    input  logic        csrfilein_csr_write,
    input  logic        csrfilein_is_mret,
    input  logic        csrfilein_is_sret,
    input  logic [31:0] csrfilein_rs1_data,
    input  logic [31:0] csrfilein_pc,
    output logic [31:0] csrfileout_rdata,
    output logic        csrfileout_redirect,
    output logic [31:0] csrfileout_redirect_pc
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_SSTATUS = 12'h100;
    localparam logic [11:0] ADDR_STVEC   = 12'h105;
    localparam logic [11:0] ADDR_SEPC    = 12'h141;
    localparam logic [11:0] ADDR_SCAUSE  = 12'h142;
    localparam logic [11:0] ADDR_SATP    = 12'h180;

    localparam logic [31:0] INST_ECALL = 32'h0000_0073;
    localparam logic [31:0] INST_UNIMP = 32'hc000_1073;

    typedef enum logic {S_IDLE, S_REDIRECT} state_e;

    state_e      state_q, state_d;
    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
`ifdef CSR_SMODE_EN
    logic [31:0] sstatus_q, sstatus_d;
    logic [31:0] stvec_q, stvec_d;
    logic [31:0] sepc_q, sepc_d;
    logic [31:0] scause_q, scause_d;
    logic [31:0] satp_q, satp_d;
`endif

    // Instruction fields
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1_field;
    logic [11:0] csr_addr;
    assign opcode    = csrfilein_inst[6:0];
    assign funct3    = csrfilein_inst[14:12];
    assign rs1_field = csrfilein_inst[19:15];
    assign csr_addr  = csrfilein_inst[31:20];

    logic        is_csr_op;
    logic [31:0] operand;
    logic        squash;
    logic        commit;
    logic        is_ecall;
    logic        is_unimp;
    logic        trap_evt;
    logic        mret_evt;
    logic        sret_evt;
    logic        csr_we;
    logic [31:0] old_val;
    logic [31:0] new_val;

    // The funct3 values 000 and 100 are not CSR ops (ecall/xret, reserved).
    assign is_csr_op = (opcode == 7'b1110011) && (funct3[1:0] != 2'b00);
    assign operand   = funct3[2] ? {27'd0, rs1_field} : csrfilein_rs1_data;
    assign squash    = (state_q == S_REDIRECT);
    assign commit    = csrfilein_valid && !csrfilein_stall && !squash;
    assign is_ecall  = (csrfilein_inst == INST_ECALL);
    assign is_unimp  = (csrfilein_inst == INST_UNIMP);
    assign trap_evt  = commit && csrfilein_csr_write && (is_ecall || is_unimp);
    assign mret_evt  = commit && csrfilein_is_mret;
`ifdef CSR_SMODE_EN
    assign sret_evt  = commit && csrfilein_is_sret;
`else
    // sret is decoded upstream, but it has no effect without S-mode.
    logic        unused_sret;
    logic [31:0] unused_stvec_rst;
    assign unused_sret      = csrfilein_is_sret;
    assign unused_stvec_rst = STVEC_RST;
    assign sret_evt         = 1'b0;
`endif

    // The unimp word is encoded as csrrw x0,cycle,x0. It traps instead of acting as a CSR write.
    // A set or clear op with rs1 field 0 only reads the CSR, so it has no write side effect.
    assign csr_we = commit && csrfilein_csr_write && is_csr_op && !is_unimp &&
                    ((funct3[1:0] == 2'b01) || (rs1_field != 5'd0));

    // Read mux for the addressed CSR. Unimplemented addresses read as 0.
    always_comb begin
        old_val = 32'd0;
        case (csr_addr)
            ADDR_MSTATUS: old_val = mstatus_q;
            ADDR_MTVEC:   old_val = mtvec_q;
            ADDR_MEPC:    old_val = mepc_q;
            ADDR_MCAUSE:  old_val = mcause_q;
`ifdef CSR_SMODE_EN
            ADDR_SSTATUS: old_val = sstatus_q;
            ADDR_STVEC:   old_val = stvec_q;
            ADDR_SEPC:    old_val = sepc_q;
            ADDR_SCAUSE:  old_val = scause_q;
            ADDR_SATP:    old_val = satp_q;
`endif
            default:      old_val = 32'd0;
        endcase
    end

    assign csrfileout_rdata = is_csr_op ? old_val : 32'd0;

    // Compute the read-modify-write result for the op in funct3.
    always_comb begin
        new_val = operand;
        case (funct3[1:0])
            2'b10:   new_val = old_val | operand;
            2'b11:   new_val = old_val & ~operand;
            default: new_val = operand;
        endcase
    end

    // Next-state logic for the CSRs: CSR op writes, then trap and return side effects.
    always_comb begin
        mstatus_d     = mstatus_q;
        mtvec_d       = mtvec_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        redirect_pc_d = redirect_pc_q;
`ifdef CSR_SMODE_EN
        sstatus_d     = sstatus_q;
        stvec_d       = stvec_q;
        sepc_d        = sepc_q;
        scause_d      = scause_q;
        satp_d        = satp_q;
`endif
        if (csr_we) begin
            case (csr_addr)
                ADDR_MSTATUS: mstatus_d = new_val;
                ADDR_MTVEC:   mtvec_d   = new_val;
                ADDR_MEPC:    mepc_d    = new_val;
                ADDR_MCAUSE:  mcause_d  = new_val;
`ifdef CSR_SMODE_EN
                ADDR_SSTATUS: sstatus_d = new_val;
                ADDR_STVEC:   stvec_d   = new_val;
                ADDR_SEPC:    sepc_d    = new_val;
                ADDR_SCAUSE:  scause_d  = new_val;
                ADDR_SATP:    satp_d    = new_val;
`endif
                default: ;
            endcase
        end
        if (trap_evt) begin
            mepc_d          = csrfilein_pc;
            mcause_d        = is_unimp ? 32'd2 : 32'd11;
            mstatus_d[7]    = mstatus_q[3];
            mstatus_d[3]    = 1'b0;
            mstatus_d[12:11] = 2'b11;
            redirect_pc_d   = {mtvec_q[31:2], 2'b00};
        end else if (mret_evt) begin
            mstatus_d[3]     = mstatus_q[7];
            mstatus_d[7]     = 1'b1;
            mstatus_d[12:11] = 2'b00;
            redirect_pc_d    = mepc_q;
        end
`ifdef CSR_SMODE_EN
        else if (sret_evt) begin
            sstatus_d[1]  = sstatus_q[5];
            sstatus_d[5]  = 1'b1;
            sstatus_d[8]  = 1'b0;
            redirect_pc_d = sepc_q;
        end
`endif
    end

    // Redirect FSM next state: any trap or return event enters REDIRECT for exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (trap_evt || mret_evt || sret_evt) state_d = S_REDIRECT;
            S_REDIRECT: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // State registers. Reset overrides any same-cycle commit or pending redirect.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            mstatus_q     <= 32'd0;
            mtvec_q       <= MTVEC_RST;
            mepc_q        <= 32'd0;
            mcause_q      <= 32'd0;
            redirect_pc_q <= 32'd0;
`ifdef CSR_SMODE_EN
            sstatus_q     <= 32'd0;
            stvec_q       <= STVEC_RST;
            sepc_q        <= 32'd0;
            scause_q      <= 32'd0;
            satp_q        <= 32'd0;
`endif
        end else begin
            state_q       <= state_d;
            mstatus_q     <= mstatus_d;
            mtvec_q       <= mtvec_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            redirect_pc_q <= redirect_pc_d;
`ifdef CSR_SMODE_EN
            sstatus_q     <= sstatus_d;
            stvec_q       <= stvec_d;
            sepc_q        <= sepc_d;
            scause_q      <= scause_d;
            satp_q        <= satp_d;
`endif
        end
    end

    assign csrfileout_redirect    = (state_q == S_REDIRECT);
    assign csrfileout_redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file.
// The main stimulus comes from a table of vectors. The S-mode sequence is written by hand.
// Each vector is applied for one cycle. Combinational rdata is checked before the rising edge.
// The expected redirect and redirect_pc values go into a scoreboard queue.
// A monitor pops and compares them just after the edge.
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid;
    logic        stall;
    logic [31:0] inst;
    logic        csr_write;
    logic        is_mret;
    logic        is_sret;
    logic [31:0] rs1_data;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        redirect;
    logic [31:0] redirect_pc;

`ifdef CSR_SMODE_EN
    localparam bit SMODE = 1'b1;
`else
    localparam bit SMODE = 1'b0;
`endif

    csr_file dut (
        .clk                    (clk),
        .rstn                   (rstn),
        .csrfilein_valid        (valid),
        .csrfilein_stall        (stall),
        .csrfilein_inst         (inst),
        .csrfilein_csr_write    (csr_write),
        .csrfilein_is_mret      (is_mret),
        .csrfilein_is_sret      (is_sret),
        .csrfilein_rs1_data     (rs1_data),
        .csrfilein_pc           (pc),
        .csrfileout_rdata       (rdata),
        .csrfileout_redirect    (redirect),
        .csrfileout_redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          rstn;
        bit          valid;
        bit          stall;
        bit          csr_write;
        bit          mret;
        bit          sret;
        logic [31:0] inst;
        logic [31:0] rs1;
        logic [31:0] pc;
        logic [31:0] exp_rdata;
        bit          exp_redir;
        logic [31:0] exp_rpc;
    } vec_t;

    typedef struct {
        string       name;
        bit          redir;
        logic [31:0] rpc;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [31:0] UNIMP = 32'hc000_1073;
    localparam logic [31:0] MRET  = 32'h3020_0073;
    localparam logic [31:0] SRET  = 32'h1020_0073;

    function automatic logic [31:0] csr_inst(input logic [2:0] f3, input logic [11:0] csr,
                                             input logic [4:0] rs1f);
        return {csr, rs1f, f3, 5'd1, 7'b1110011};
    endfunction

    function automatic vec_t mk(input string nm, input bit rn, input bit v, input bit st,
                                input bit cw, input bit mr, input bit sr, input logic [31:0] in,
                                input logic [31:0] r1, input logic [31:0] p, input logic [31:0] er,
                                input bit ered, input logic [31:0] erpc);
        vec_t t;
        t.name = nm; t.rstn = rn; t.valid = v; t.stall = st; t.csr_write = cw;
        t.mret = mr; t.sret = sr; t.inst = in; t.rs1 = r1; t.pc = p;
        t.exp_rdata = er; t.exp_redir = ered; t.exp_rpc = erpc;
        return t;
    endfunction

    // Read-only access: csrrs x1,csr,x0 returns the CSR and never writes
    function automatic vec_t rd(input string nm, input logic [11:0] csr, input logic [31:0] er,
                                input logic [31:0] erpc);
        return mk(nm, 1, 1, 0, 1, 0, 0, csr_inst(3'b010, csr, 5'd0), 32'd0, 32'd0, er, 0, erpc);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        @(negedge clk);
        rstn = t.rstn; valid = t.valid; stall = t.stall; csr_write = t.csr_write;
        is_mret = t.mret; is_sret = t.sret; inst = t.inst; rs1_data = t.rs1; pc = t.pc;
        #2;
        check({t.name, " rdata"}, rdata, t.exp_rdata);
        sb.push_back('{t.name, t.exp_redir, t.exp_rpc});
        $display("txn %-22s inst=%h rdata=%h", t.name, t.inst, rdata);
    endtask

    // Monitor: pop one expectation after each edge that follows a driven vector
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            sb_t e;
            e = sb.pop_front();
            check({e.name, " redirect"}, {31'd0, redirect}, {31'd0, e.redir});
            check({e.name, " redirect_pc"}, redirect_pc, e.rpc);
        end
    end

    localparam logic [31:0] V0100 = 32'h8000_0100;
    localparam logic [31:0] V0044 = 32'h8000_0044;

    initial begin
        rstn = 0; valid = 0; stall = 0; inst = 0; csr_write = 0;
        is_mret = 0; is_sret = 0; rs1_data = 0; pc = 0;

        // Vector table: reset, CSR ops, traps, returns, stall, squash, reset overrides
        vecs.push_back(mk("reset0", 0, 0, 0, 0, 0, 0, 32'd0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("reset1", 0, 0, 0, 0, 0, 0, 32'd0, 0, 0, 0, 0, 0));
        vecs.push_back(rd("rst_mtvec", 12'h305, 32'd0, 0));
        vecs.push_back(rd("rst_mstatus", 12'h300, 32'd0, 0));
        vecs.push_back(mk("csrrw_mtvec", 1, 1, 0, 1, 0, 0, csr_inst(3'b001, 12'h305, 5'd2), V0100, 0, 32'd0, 0, 0));
        vecs.push_back(rd("rd_mtvec", 12'h305, V0100, 0));
        vecs.push_back(mk("csrrw_mstatus", 1, 1, 0, 1, 0, 0, csr_inst(3'b001, 12'h300, 5'd2), 32'h88, 0, 32'd0, 0, 0));
        vecs.push_back(mk("csrrci_mstatus8", 1, 1, 0, 1, 0, 0, csr_inst(3'b111, 12'h300, 5'd8), 0, 0, 32'h88, 0, 0));
        vecs.push_back(rd("rd_mstatus_rc", 12'h300, 32'h80, 0));
        vecs.push_back(mk("csrrs_rs1f0", 1, 1, 0, 1, 0, 0, csr_inst(3'b010, 12'h300, 5'd0), 32'hffff_ffff, 0, 32'h80, 0, 0));
        vecs.push_back(rd("rd_mstatus_rs0", 12'h300, 32'h80, 0));
        vecs.push_back(mk("csrrc_no_cw", 1, 1, 0, 0, 0, 0, csr_inst(3'b011, 12'h300, 5'd3), 32'h80, 0, 32'h80, 0, 0));
        vecs.push_back(rd("rd_mstatus_nocw", 12'h300, 32'h80, 0));
        vecs.push_back(mk("csrrw_mtvec103", 1, 1, 0, 1, 0, 0, csr_inst(3'b001, 12'h305, 5'd2), 32'h8000_0103, 0, V0100, 0, 0));
        vecs.push_back(mk("csrrsi_mie", 1, 1, 0, 1, 0, 0, csr_inst(3'b110, 12'h300, 5'd8), 0, 0, 32'h80, 0, 0));
        vecs.push_back(mk("ecall_stalled", 1, 1, 1, 1, 0, 0, ECALL, 0, 32'h8000_0040, 32'd0, 0, 0));
        vecs.push_back(rd("rd_mepc_stall", 12'h341, 32'd0, 0));
        vecs.push_back(mk("ecall", 1, 1, 0, 1, 0, 0, ECALL, 0, 32'h8000_0040, 32'd0, 1, V0100));
        vecs.push_back(mk("squash_csrrw", 1, 1, 0, 1, 0, 0, csr_inst(3'b001, 12'h305, 5'd2), 32'hdead, 0, 32'h8000_0103, 0, V0100));
        vecs.push_back(rd("rd_mtvec_sq", 12'h305, 32'h8000_0103, V0100));
        vecs.push_back(rd("rd_mepc_ecall", 12'h341, 32'h8000_0040, V0100));
        vecs.push_back(rd("rd_mcause_ecall", 12'h342, 32'd11, V0100));
        vecs.push_back(rd("rd_mstatus_ecall", 12'h300, 32'h1880, V0100));
        vecs.push_back(mk("csrrw_mepc", 1, 1, 0, 1, 0, 0, csr_inst(3'b001, 12'h341, 5'd2), V0044, 0, 32'h8000_0040, 0, V0100));
        vecs.push_back(mk("mret", 1, 1, 0, 1, 1, 0, MRET, 0, 0, 32'd0, 1, V0044));
        vecs.push_back(mk("squash_mret", 1, 1, 0, 1, 0, 0, csr_inst(3'b001, 12'h342, 5'd2), 32'h55, 0, 32'd11, 0, V0044));
        vecs.push_back(rd("rd_mcause_sq", 12'h342, 32'd11, V0044));
        vecs.push_back(rd("rd_mstatus_mret", 12'h300, 32'h88, V0044));
        vecs.push_back(mk("unimp", 1, 1, 0, 1, 0, 0, UNIMP, 32'h77, 32'h8000_0080, 32'd0, 1, V0100));
        vecs.push_back(mk("idle", 1, 0, 0, 0, 0, 0, 32'd0, 0, 0, 32'd0, 0, V0100));
        vecs.push_back(rd("rd_mcause_unimp", 12'h342, 32'd2, V0100));
        vecs.push_back(rd("rd_mepc_unimp", 12'h341, 32'h8000_0080, V0100));
        vecs.push_back(rd("rd_mstatus_unimp", 12'h300, 32'h1880, V0100));
        vecs.push_back(mk("ecall2", 1, 1, 0, 1, 0, 0, ECALL, 0, 32'h8000_00c0, 32'd0, 1, V0100));
        vecs.push_back(mk("stall_in_redir", 1, 1, 1, 1, 0, 0, ECALL, 0, 32'h8000_00c4, 32'd0, 0, V0100));
        vecs.push_back(mk("rst_with_ecall", 0, 1, 0, 1, 0, 0, ECALL, 0, 32'h8000_0100, 32'd0, 0, 0));
        vecs.push_back(rd("rd_mepc_rst", 12'h341, 32'd0, 0));
        vecs.push_back(rd("rd_mtvec_rst", 12'h305, 32'd0, 0));
        vecs.push_back(rd("rd_mcause_rst", 12'h342, 32'd0, 0));
        vecs.push_back(mk("ecall3", 1, 1, 0, 1, 0, 0, ECALL, 0, 32'h44, 32'd0, 1, 0));
        vecs.push_back(mk("rst_in_redir", 0, 0, 0, 0, 0, 0, 32'd0, 0, 0, 32'd0, 0, 0));
        vecs.push_back(rd("rd_unimpl_addr", 12'h7c0, 32'd0, 0));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // S-mode sequence: program sepc and sstatus.SPIE, then sret
        apply(mk("csrrw_sepc", 1, 1, 0, 1, 0, 0, csr_inst(3'b001, 12'h141, 5'd2), 32'h8000_0200, 0, 32'd0, 0, 0));
        apply(rd("rd_sepc", 12'h141, SMODE ? 32'h8000_0200 : 32'd0, 0));
        apply(mk("csrrw_sstatus", 1, 1, 0, 1, 0, 0, csr_inst(3'b001, 12'h100, 5'd2), 32'h20, 0, 32'd0, 0, 0));
        apply(mk("sret", 1, 1, 0, 1, 0, 1, SRET, 0, 0, 32'd0, SMODE, SMODE ? 32'h8000_0200 : 32'd0));
        apply(rd("rd_sstatus_sret", 12'h100, SMODE ? 32'h22 : 32'd0, SMODE ? 32'h8000_0200 : 32'd0));
        apply(rd("rd_stvec", 12'h105, 32'd0, SMODE ? 32'h8000_0200 : 32'd0));

        @(posedge clk);
        #3;
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter MTVEC_RST, default 32'h0000_0000, reset value of mtvec.
REQ-002 SHALL have parameter STVEC_RST, default 32'h0000_0000, reset value of stvec.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rstn  input  1  synchronous reset, active-low.
REQ-005 SHALL have port csrfilein_valid  input  1  instruction present in MEM stage this cycle.
REQ-006 SHALL have port csrfilein_stall  input  1  MEM stage held; no commit while 1.
REQ-007 SHALL have port csrfilein_inst  input  32  MEM-stage instruction word.
REQ-008 SHALL have port csrfilein_csr_write  input  1  decoder permits CSR/trap update.
REQ-009 SHALL have port csrfilein_is_mret  input  1  decoder flag, mret (32'h30200073).
REQ-010 SHALL have port csrfilein_is_sret  input  1  decoder flag, sret (32'h10200073).
REQ-011 SHALL have port csrfilein_rs1_data  input  32  rs1 operand for register-form CSR ops.
REQ-012 SHALL have port csrfilein_pc  input  32  PC of MEM-stage instruction.
REQ-013 SHALL have port csrfileout_rdata  output  32  old CSR value for rd writeback, combinational.
REQ-014 SHALL have port csrfileout_redirect  output  1  registered one-cycle PC-redirect/flush pulse.
REQ-015 SHALL have port csrfileout_redirect_pc  output  32  registered redirect target.

Function
REQ-016 SHALL hold 32-bit mstatus(300), mtvec(305), mepc(341), mcause(342), sstatus(100), stvec(105), sepc(141), scause(142), satp(180).
REQ-017 SHALL define commit = valid & ~stall & ~squash, where squash = FSM in REDIRECT.
REQ-018 SHALL decode funct3 = inst[14:12]: 001 RW, 010 RS, 011 RC; 101/110/111 same with operand = zero-extended inst[19:15].
REQ-019 SHALL on commit & csr_write & CSR op: RW new=op; RS new=old|op; RC new=old&~op; RS/RC with rs1 field 0 SHALL NOT write.
REQ-020 SHALL drive rdata = current value of CSR at inst[31:20], 0 for unimplemented address, 0 when not a CSR op.
REQ-021 SHALL on commit & csr_write & inst==32'h00000073 (ecall): mepc<=pc, mcause<=11, mstatus.MPIE<=MIE, MIE<=0, MPP<=2'b11; redirect to {mtvec[31:2],2'b00}.
REQ-022 SHALL on commit & csr_write & inst==32'hc0001073 (unimp): as REQ-021 with mcause<=2, CSR op suppressed.
REQ-023 SHALL on commit & is_mret: MIE<=MPIE, MPIE<=1, MPP<=0; redirect to mepc.
REQ-024 SHALL on commit & is_sret: sstatus.SIE<=SPIE, SPIE<=1, SPP<=0; redirect to sepc.
REQ-025 SHALL implement FSM IDLE/REDIRECT: IDLE->REDIRECT on any REQ-021..024 event; REDIRECT->IDLE unconditionally next cycle.
REQ-026 SHALL assert redirect exactly in REDIRECT, with redirect_pc latched at the event edge (latency 1 cycle).
REQ-027 SHALL ignore valid while in REDIRECT (wrong-path slot squashed, no CSR update).
REQ-028 SHALL, with stall=1, make no state change and keep FSM in IDLE; REDIRECT still exits after one cycle.
REQ-029 SHALL use updated values for a commit one cycle after a prior write (write-then-read returns new value).

Reset
REQ-030 SHALL, when rstn=0 at a rising edge, set all CSRs to 0 except mtvec=MTVEC_RST, stvec=STVEC_RST; FSM IDLE; redirect=0; redirect_pc=0.
REQ-031 SHALL let reset override a same-cycle commit or pending REDIRECT (no pulse after reset).

Configuration
REQ-032 SHALL provide macro CSR_SMODE_EN: defined -> sstatus/stvec/sepc/scause/satp and sret implemented.
REQ-033 SHALL, without CSR_SMODE_EN, read S-CSRs as 0, ignore writes, treat is_sret as no-op (no redirect).

Verification
REQ-034 SHALL test CSRRW: rs1_data=32'h8000_0100, inst csrrw x1,mtvec,x2 -> rdata=0 that cycle, next read mtvec=32'h8000_0100.
REQ-035 SHALL test CSRRS/RC: mstatus=32'h0000_0088, csrrci mstatus,8 -> mstatus=32'h0000_0080; csrrs rs1field=0 -> unchanged.
REQ-036 SHALL test ecall: mtvec=32'h8000_0103, pc=32'h8000_0040, MIE=1 -> mepc=32'h8000_0040, mcause=11, MPIE=1, MIE=0, next-cycle redirect=1, redirect_pc=32'h8000_0100.
REQ-037 SHALL test mret: mepc=32'h8000_0044, MPIE=1 -> MIE=1, one-cycle redirect to 32'h8000_0044; valid csrrw in that cycle -> no write.
REQ-038 SHALL test stall/reset: ecall with stall=1 -> no change; rstn=0 same edge as ecall commit -> CSRs reset, no redirect.
REQ-039 SHALL test both CSR_SMODE_EN builds: sret with sepc=32'h8000_0200 -> redirect to it when defined, no redirect and rdata=0 for sepc when undefined.
